// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (serial_adder,
// serial_subtractor).
//   state_e : FSM encoding shared by the serial arithmetic controllers.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
// Purely combinational; the borrow storage lives in the parent.
//   a    in  1  minuend bit
//   b    in  1  subtrahend bit
//   bin  in  1  borrow-in
//   d    out 1  difference bit
//   bout out 1  borrow-out
module serial_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: latches A and B on an accepted start and computes
// A - B LSB-first, one bit per clock, using a single borrow flip-flop.
// {borrow, diff} is the WIDTH+1-bit two's-complement result.
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   strt   in   1      start request, sampled only in IDLE
//   A      in   WIDTH  minuend, sampled on the accepting edge
//   B      in   WIDTH  subtrahend, sampled on the accepting edge
//   diff   out  WIDTH  A - B modulo 2^WIDTH, held until the next result
//   borrow out  1      final borrow-out (A < B unsigned)
//   busy   out  1      high in RUN and DONE
//   done   out  1      one-cycle pulse when diff/borrow are valid
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bff_q, bff_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic cell_d, cell_bout;

  serial_sub_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bff_q),
    .d    (cell_d),
    .bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    bff_d    = bff_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (strt) begin
          a_sh_d  = A;
          b_sh_d  = B;
          bff_d   = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // Result fills from the MSB end so the last bit lands it fully aligned.
        res_d  = {cell_d, res_q[WIDTH-1:1]};
        bff_d  = cell_bout;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          diff_d   = res_d;
          borrow_d = cell_bout;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      bff_q    <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bff_q    <= bff_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       strt;
  logic [7:0] A, B;
  logic [7:0] diff;
  logic       borrow, busy, done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .strt   (strt),
    .A      (A),
    .B      (B),
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one op from IDLE; A/B are scrambled after the accepting edge.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_b);
    int k;
    A = a; B = b; strt = 1'b1;
    @(negedge clk);
    strt = 1'b0; A = ~a; B = a;
    check("busy_after_accept", busy, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 20);
    check("done_latency", k, 8);
    check("diff", diff, exp_d);
    check("borrow", borrow, exp_b);
    check("busy_in_done", busy, 1);
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    logic [7:0] va, vb, acc_a, acc_b, hold_d;
    logic       hold_b;
    int         nb, nd;

    rst = 1'b1; strt = 1'b0; A = '0; B = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(8'h55, 8'h33, 8'h22, 1'b0);
    run_op(8'h33, 8'h55, 8'hDE, 1'b1);
    run_op(8'hB3, 8'hD5, 8'hDE, 1'b1);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0);
    run_op(8'h80, 8'h7F, 8'h01, 1'b0);
    run_op(8'hA5, 8'h5A, 8'h4B, 1'b0);

    // strt held high, operands changing every cycle: accepts at 0, 10, 20.
    acc_a = '0; acc_b = '0;
    for (int i = 0; i < 30; i++) begin
      check("stream_done", done, (i % 10 == 9) ? 1 : 0);
      if (i % 10 == 9) begin
        check("stream_diff", diff, 8'(acc_a - acc_b));
        check("stream_borrow", borrow, (acc_a < acc_b) ? 1 : 0);
      end
      va = 8'(i * 37 + 5);
      vb = 8'(i * 91 + 13);
      A = va; B = vb; strt = 1'b1;
      if (i % 10 == 0) begin
        acc_a = va; acc_b = vb;
      end
      @(negedge clk);
    end
    strt = 1'b0;
    @(negedge clk);
    check("stream_idle", busy, 0);

    // Reset in the middle of a run.
    A = 8'h12; B = 8'h34; strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_diff", diff, 0);
    check("midrst_borrow", borrow, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    #1 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("midrst_no_done", nd, 0);
    run_op(8'h12, 8'h34, 8'hDE, 1'b1);

    // strt pulsed during RUN and during DONE must be ignored.
    A = 8'h9C; B = 8'h21; strt = 1'b1;
    @(negedge clk);
    strt = 1'b0;
    nb = busy ? 1 : 0;
    nd = 0;
    for (int k = 1; k <= 14; k++) begin
      strt = (k == 3 || k == 9) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
    end
    strt = 1'b0;
    check("busy_cycles", nb, 9);
    check("done_count", nd, 1);
    hold_d = diff; hold_b = borrow;
    check("ign_diff", diff, 8'h7B);
    check("ign_borrow", borrow, 0);
    repeat (5) @(negedge clk);
    check("hold_diff", diff, 8'h7B);
    check("hold_borrow", borrow, hold_b);
    check("hold_busy", busy, 0);
    check("hold_diff_stable", diff, hold_d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
